// File: rtl/l2_calc_pkg.sv
// rtl/l2_calc_pkg.sv - shared constants and types for the Lab2 calculator sequencer
// Purpose: ASCII constants, sequencer state enum and character-class enum.
// Ports: none (package).
package l2_calc_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_BANG  = 8'h21;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_OP,
    ST_GET_R2,
    ST_GET_EQ,
    ST_START,
    ST_WAIT_RDY,
    ST_SEND_RES,
    ST_SEND_CR,
    ST_SEND_LF,
    ST_SEND_ERR
  } state_t;

  typedef enum logic [2:0] {
    CLS_DIGIT,
    CLS_PLUS,
    CLS_MINUS,
    CLS_EQ,
    CLS_SPACE,
    CLS_OTHER
  } char_cls_t;

endpackage

// File: rtl/l2_char_class.sv
// rtl/l2_char_class.sv - combinational ASCII character classifier
// Purpose: maps a received byte onto the token classes the parser cares about.
// Ports:
//   ch_i   in  8  byte to classify
//   cls_o  out    class (DIGIT, PLUS, MINUS, EQ, SPACE, OTHER)
module l2_char_class
  import l2_calc_pkg::*;
(
  input  logic [7:0] ch_i,
  output char_cls_t  cls_o
);

  always_comb begin
    cls_o = CLS_OTHER;
    if (ch_i >= ASCII_0 && ch_i <= ASCII_9) begin
      cls_o = CLS_DIGIT;
    end else if (ch_i == ASCII_PLUS) begin
      cls_o = CLS_PLUS;
    end else if (ch_i == ASCII_MINUS) begin
      cls_o = CLS_MINUS;
    end else if (ch_i == ASCII_EQ) begin
      cls_o = CLS_EQ;
    end else if (ch_i == ASCII_SPACE) begin
      cls_o = CLS_SPACE;
    end
  end

endmodule

// File: rtl/l2_calc_sequencer.sv
// rtl/l2_calc_sequencer.sv - parses "d op d =" from UART RX, drives the adder, returns result + CR/LF
// Purpose: front-end initiator for the Lab2 adder/subtractor.
// Ports:
//   clk, Gl_rst_n                 clock, async active-low reset
//   Gl_rx_valid, Gl_rx_data[8]    received byte pulse from UART RX
//   L2_adder_data[8], L2_adder_rdy  result byte and ready pulse from the adder
//   Gl_tx_ready                   UART TX can take a byte this cycle
//   Sq_r1[8], Sq_r2[8], Sq_subtract  operands and operation to the adder
//   Sq_adder_start                one-cycle start pulse
//   Sq_tx_data[8], Sq_tx_valid    byte stream to UART TX
//   Sq_busy                       high whenever not idle
//   Sq_rx_drop                    pulse when an rx byte arrives outside parsing
module l2_calc_sequencer
  import l2_calc_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       Gl_rst_n,
  input  logic       Gl_rx_valid,
  input  logic [7:0] Gl_rx_data,
  input  logic [7:0] L2_adder_data,
  input  logic       L2_adder_rdy,
  input  logic       Gl_tx_ready,
  output logic [7:0] Sq_r1,
  output logic [7:0] Sq_r2,
  output logic       Sq_subtract,
  output logic       Sq_adder_start,
  output logic [7:0] Sq_tx_data,
  output logic       Sq_tx_valid,
  output logic       Sq_busy,
  output logic       Sq_rx_drop
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Last counter value of the wait window; the timeout fires on the edge leaving it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       r1_q, r1_d;
  logic [7:0]       r2_q, r2_d;
  logic             sub_q, sub_d;
  logic [7:0]       res_q, res_d;
  logic [7:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  char_cls_t        rx_cls;
  logic             parse_st;

  l2_char_class u_char_class (
    .ch_i  (Gl_rx_data),
    .cls_o (rx_cls)
  );

  always_ff @(posedge clk or negedge Gl_rst_n) begin
    if (!Gl_rst_n) begin
      state_q <= ST_IDLE;
      r1_q    <= '0;
      r2_q    <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    r1_d           = r1_q;
    r2_d           = r2_q;
    sub_d          = sub_q;
    res_d          = res_q;
    err_d          = err_q;
    cnt_d          = cnt_q;
    Sq_adder_start = 1'b0;
    Sq_tx_valid    = 1'b0;
    Sq_tx_data     = '0;
    parse_st       = (state_q inside {ST_IDLE, ST_GET_OP, ST_GET_R2, ST_GET_EQ});

    // Parse states: spaces are transparent, anything unexpected becomes '?'.
    if (parse_st && Gl_rx_valid && rx_cls != CLS_SPACE) begin
      state_d = ST_SEND_ERR;
      err_d   = ASCII_QMARK;
      case (state_q)
        ST_IDLE: if (rx_cls == CLS_DIGIT) begin
          r1_d    = Gl_rx_data;
          state_d = ST_GET_OP;
        end
        ST_GET_OP: if (rx_cls == CLS_PLUS || rx_cls == CLS_MINUS) begin
          sub_d   = (rx_cls == CLS_MINUS);
          state_d = ST_GET_R2;
        end
        ST_GET_R2: if (rx_cls == CLS_DIGIT) begin
          r2_d    = Gl_rx_data;
          state_d = ST_GET_EQ;
        end
        ST_GET_EQ: if (rx_cls == CLS_EQ) begin
          state_d = ST_START;
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_START: begin
        Sq_adder_start = 1'b1;
        cnt_d          = '0;
        state_d        = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        // rdy is checked first so it wins over a coincident timeout.
        if (L2_adder_rdy) begin
          res_d   = L2_adder_data;
          state_d = ST_SEND_RES;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = ASCII_BANG;
          state_d = ST_SEND_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SEND_RES, ST_SEND_ERR: begin
        Sq_tx_valid = 1'b1;
        Sq_tx_data  = (state_q == ST_SEND_RES) ? res_q : err_q;
        if (Gl_tx_ready) state_d = ST_SEND_CR;
      end
      ST_SEND_CR: begin
        Sq_tx_valid = 1'b1;
        Sq_tx_data  = ASCII_CR;
        if (Gl_tx_ready) state_d = ST_SEND_LF;
      end
      ST_SEND_LF: begin
        Sq_tx_valid = 1'b1;
        Sq_tx_data  = ASCII_LF;
        if (Gl_tx_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  assign Sq_r1       = r1_q;
  assign Sq_r2       = r2_q;
  assign Sq_subtract = sub_q;
  assign Sq_busy     = (state_q != ST_IDLE);
  assign Sq_rx_drop  = Gl_rx_valid && !parse_st;

endmodule

// File: tb/tb_l2_calc_sequencer.sv
// tb/tb_l2_calc_sequencer.sv - self-checking bench for l2_calc_sequencer
// Purpose: directed and randomized lines against a line-level reference model.
// Ports: none (top-level bench).
module tb_l2_calc_sequencer;

  localparam int TIMEOUT = 15;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       Gl_rst_n, Gl_rx_valid, L2_adder_rdy, Gl_tx_ready;
  logic [7:0] Gl_rx_data, L2_adder_data;
  logic [7:0] Sq_r1, Sq_r2, Sq_tx_data;
  logic       Sq_subtract, Sq_adder_start, Sq_tx_valid, Sq_busy, Sq_rx_drop;

  l2_calc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .Gl_rst_n       (Gl_rst_n),
    .Gl_rx_valid    (Gl_rx_valid),
    .Gl_rx_data     (Gl_rx_data),
    .L2_adder_data  (L2_adder_data),
    .L2_adder_rdy   (L2_adder_rdy),
    .Gl_tx_ready    (Gl_tx_ready),
    .Sq_r1          (Sq_r1),
    .Sq_r2          (Sq_r2),
    .Sq_subtract    (Sq_subtract),
    .Sq_adder_start (Sq_adder_start),
    .Sq_tx_data     (Sq_tx_data),
    .Sq_tx_valid    (Sq_tx_valid),
    .Sq_busy        (Sq_busy),
    .Sq_rx_drop     (Sq_rx_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: records transfers, start pulses, drops and tx hold violations.
  logic [7:0] tx_log[$];
  int   n_start = 0, n_drop = 0, n_hold_bad = 0;
  int   start_cyc = -1, tx_rise_cyc = -1;
  logic prev_hold = 1'b0, prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  initial forever begin
    @(negedge clk);
    if (!Gl_rst_n) begin
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_hold && (!Sq_tx_valid || Sq_tx_data !== prev_data)) n_hold_bad++;
      if (Sq_tx_valid && !prev_valid) tx_rise_cyc = cyc;
      if (Sq_tx_valid && Gl_tx_ready) tx_log.push_back(Sq_tx_data);
      if (Sq_adder_start) begin
        n_start++;
        start_cyc = cyc;
      end
      if (Sq_rx_drop) n_drop++;
      prev_hold  = Sq_tx_valid && !Gl_tx_ready;
      prev_valid = Sq_tx_valid;
      prev_data  = Sq_tx_data;
    end
  end

  // Adder model: answers adder_dly cycles after a start pulse (0 = never).
  int         adder_dly = 0;
  logic [7:0] adder_val = 8'h00;
  int         rdy_cyc = -1;
  initial begin
    L2_adder_rdy  = 1'b0;
    L2_adder_data = 8'h00;
    forever begin
      @(negedge clk);
      if (Gl_rst_n && Sq_adder_start && adder_dly > 0) begin
        repeat (adder_dly) @(posedge clk);
        #1;
        L2_adder_rdy  = 1'b1;
        L2_adder_data = adder_val;
        rdy_cyc       = cyc;
        @(posedge clk);
        #1;
        L2_adder_rdy  = 1'b0;
        L2_adder_data = ~adder_val;
      end
    end
  end

  // TX sink: 0 = always ready, 1 = random, 2 = stalled.
  int ready_mode = 0;
  initial begin
    Gl_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       Gl_tx_ready = 1'b1;
        1:       Gl_tx_ready = 1'($urandom_range(0, 1));
        default: Gl_tx_ready = 1'b0;
      endcase
    end
  end

  int byte_cyc = 0;
  task automatic send_byte(input logic [7:0] b, input int gap);
    Gl_rx_valid = 1'b1;
    Gl_rx_data  = b;
    byte_cyc    = cyc;
    step();
    Gl_rx_valid = 1'b0;
    Gl_rx_data  = 8'($urandom);
    repeat (gap) step();
  endtask

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t rand_line();
    bq_t        q;
    logic [7:0] items[4];
    logic [7:0] bad;
    items[0] = 8'h30 + 8'($urandom_range(0, 9));
    items[1] = ($urandom_range(0, 1) == 1) ? 8'h2B : 8'h2D;
    items[2] = 8'h30 + 8'($urandom_range(0, 9));
    items[3] = 8'h3D;
    if ($urandom_range(0, 2) == 0) begin
      bad = 8'($urandom);
      if (bad == 8'h20) bad = 8'h40;
      items[$urandom_range(0, 3)] = bad;
    end
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 3) == 0) q.push_back(8'h20);
      q.push_back(items[i]);
    end
    return q;
  endfunction

  // Reference: the operand registers as they should read after every line.
  logic [7:0] exp_r1 = 8'h00, exp_r2 = 8'h00;
  logic       exp_sub = 1'b0;

  task automatic run_line(input bq_t line, input int dly, input logic [7:0] val,
                          input bit inject, input bit hold10);
    int         n_used, field, tx0, st0, dr0, hb0, eq_cyc;
    bit         ok, good, answered;
    logic [7:0] b;
    logic [7:0] exp_tx[3];
    n_used   = line.size();
    field    = 0;
    ok       = 1'b0;
    answered = (dly >= 1 && dly <= TIMEOUT);
    // A line is four tokens in order: digit, '+'/'-', digit, '='; spaces are skipped.
    // The first token that does not fit ends the line with an error.
    for (int i = 0; i < line.size(); i++) begin
      b = line[i];
      if (b == 8'h20) continue;
      case (field)
        0: begin good = (b >= 8'h30 && b <= 8'h39); if (good) exp_r1 = b; end
        1: begin good = (b == 8'h2B || b == 8'h2D); if (good) exp_sub = (b == 8'h2D); end
        2: begin good = (b >= 8'h30 && b <= 8'h39); if (good) exp_r2 = b; end
        default: good = (b == 8'h3D);
      endcase
      if (!good || field == 3) begin
        n_used = i + 1;
        ok     = good;
        break;
      end
      field++;
    end
    exp_tx[0] = !ok ? 8'h3F : (answered ? val : 8'h21);
    exp_tx[1] = 8'h0D;
    exp_tx[2] = 8'h0A;

    tx0 = tx_log.size(); st0 = n_start; dr0 = n_drop; hb0 = n_hold_bad;
    adder_dly = dly;
    adder_val = val;
    for (int i = 0; i < n_used; i++)
      send_byte(line[i], (i == n_used - 1) ? 0 : $urandom_range(0, 2));
    eq_cyc = byte_cyc;
    if (inject) send_byte(8'($urandom), 0);
    if (hold10) begin
      for (int k = 0; k < 100 && !Sq_tx_valid; k++) step();
      repeat (10) begin
        check_eq("hold_valid", int'(Sq_tx_valid), 1);
        check_eq("hold_data", int'(Sq_tx_data), int'(exp_tx[0]));
        step();
      end
      ready_mode = 0;
    end
    for (int k = 0; k < 300 && Sq_busy; k++) step();
    check_eq("line_done", int'(Sq_busy), 0);
    check_eq("tx_count", tx_log.size() - tx0, 3);
    for (int i = 0; i < 3; i++)
      if (tx0 + i < tx_log.size())
        check_eq($sformatf("tx_byte%0d", i), int'(tx_log[tx0 + i]), int'(exp_tx[i]));
    check_eq("start_pulses", n_start - st0, int'(ok));
    check_eq("rx_drops", n_drop - dr0, int'(inject));
    check_eq("tx_hold", n_hold_bad - hb0, 0);
    check_eq("r1", int'(Sq_r1), int'(exp_r1));
    check_eq("r2", int'(Sq_r2), int'(exp_r2));
    check_eq("subtract", int'(Sq_subtract), int'(exp_sub));
    check_eq("tx_valid_idle", int'(Sq_tx_valid), 0);
    if (ok) begin
      check_eq("start_latency", start_cyc - eq_cyc, 1);
      if (answered) check_eq("result_latency", tx_rise_cyc - rdy_cyc, 1);
      else          check_eq("timeout_latency", tx_rise_cyc - start_cyc, TIMEOUT + 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_r1"}, int'(Sq_r1), 0);
    check_eq({tag, "_r2"}, int'(Sq_r2), 0);
    check_eq({tag, "_sub"}, int'(Sq_subtract), 0);
    check_eq({tag, "_start"}, int'(Sq_adder_start), 0);
    check_eq({tag, "_tx_data"}, int'(Sq_tx_data), 0);
    check_eq({tag, "_tx_valid"}, int'(Sq_tx_valid), 0);
    check_eq({tag, "_busy"}, int'(Sq_busy), 0);
    check_eq({tag, "_drop"}, int'(Sq_rx_drop), 0);
  endtask

  initial begin
    bq_t q;
    Gl_rst_n    = 1'b0;
    Gl_rx_valid = 1'b0;
    Gl_rx_data  = 8'h00;
    repeat (3) step();
    check_all_zero("reset");
    Gl_rst_n = 1'b1;
    repeat (2) step();

    run_line(s2q("3+4="), 5, 8'h37, 1'b0, 1'b0);
    run_line(s2q("9 - 2 ="), 4, 8'h37, 1'b0, 1'b0);
    run_line(s2q("3x"), 5, 8'h00, 1'b0, 1'b0);
    run_line(s2q("1+1="), 0, 8'h00, 1'b1, 1'b0);
    ready_mode = 2;
    run_line(s2q("3+4="), 5, 8'h37, 1'b0, 1'b1);
    run_line(s2q("7+1="), TIMEOUT, 8'h38, 1'b0, 1'b0);
    run_line(s2q("2-2="), TIMEOUT + 1, 8'h30, 1'b0, 1'b0);

    // Reset in the middle of the adder wait.
    adder_dly = 0;
    q = s2q("1+1=");
    foreach (q[i]) send_byte(q[i], 0);
    repeat (3) step();
    check_eq("busy_before_reset", int'(Sq_busy), 1);
    #2 Gl_rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    exp_r1 = 8'h00; exp_r2 = 8'h00; exp_sub = 1'b0;
    repeat (2) step();
    Gl_rst_n = 1'b1;
    step();
    run_line(s2q("5+0="), 4, 8'h35, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ready_mode = $urandom_range(0, 1);
      run_line(rand_line(), ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(4, 5),
               8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

endmodule
